// File: rtl/tile_cursor_if.sv
// tile_cursor_if: key-event inputs and cursor-position outputs of the
// tile cursor controller. The master side produces key events and consumes
// the position; the slave side is the controller itself.
interface tile_cursor_if #(
    parameter int HW = 4,
    parameter int VW = 4
);
    logic          key_valid;
    logic [8:0]    key_code;
    logic          key_make;
    logic [HW-1:0] cur_h;
    logic [VW-1:0] cur_v;
    logic          move_pulse;
    logic [2:0]    held_dir;

    modport master (
        output key_valid, key_code, key_make,
        input  cur_h, cur_v, move_pulse, held_dir
    );

    modport slave (
        input  key_valid, key_code, key_make,
        output cur_h, cur_v, move_pulse, held_dir
    );
endinterface

// File: rtl/tile_cursor_ctrl.sv
// tile_cursor_ctrl: keypad-driven cursor for the VGA tile grid.
// Decodes PS/2 keypad make/break events (left 69, right 7A, up 72, down 73,
// home 6C; extended codes ignored) into single-tile moves, with auto-repeat
// after FIRST_DELAY cycles and then every REPEAT_PERIOD cycles while held.
// Moves clamp at the grid edges; define CURSOR_WRAP_EN to make them wrap.
// All outputs are registered.
module tile_cursor_ctrl #(
    parameter int H_TILES       = 10,
    parameter int V_TILES       = 6,
    parameter int HW            = 4,
    parameter int VW            = 4,
    parameter int CW            = 28,
    parameter int FIRST_DELAY   = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input logic         clk,
    input logic         rst,
    tile_cursor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_e;

    // Last legal column/row, held in the position width so the edge test
    // never needs an extra carry bit even when the grid fills 2^HW / 2^VW.
    localparam logic [HW-1:0] H_LAST  = HW'(H_TILES - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TILES - 1);
    localparam logic [CW-1:0] FD_LAST = CW'(FIRST_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    state_e        state_q, state_d;
    dir_e          held_q, held_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] cur_h_q, cur_h_d;
    logic [VW-1:0] cur_v_q, cur_v_d;
    logic          pulse_q, pulse_d;

    dir_e          ev_dir;
    logic          ev_home_code;
    logic          ev_dir_make;
    logic          ev_home_make;
    logic          ev_release;

    // One tile of horizontal motion from the registered column.
    function automatic logic [HW-1:0] step_col(input logic [HW-1:0] h, input dir_e d);
        step_col = h;
        if (d == DIR_LEFT) begin
`ifdef CURSOR_WRAP_EN
            step_col = (h == '0) ? H_LAST : h - HW'(1);
`else
            step_col = (h == '0) ? h : h - HW'(1);
`endif
        end else if (d == DIR_RIGHT) begin
`ifdef CURSOR_WRAP_EN
            step_col = (h == H_LAST) ? '0 : h + HW'(1);
`else
            step_col = (h == H_LAST) ? h : h + HW'(1);
`endif
        end
    endfunction

    // One tile of vertical motion from the registered row.
    function automatic logic [VW-1:0] step_row(input logic [VW-1:0] v, input dir_e d);
        step_row = v;
        if (d == DIR_UP) begin
`ifdef CURSOR_WRAP_EN
            step_row = (v == '0) ? V_LAST : v - VW'(1);
`else
            step_row = (v == '0) ? v : v - VW'(1);
`endif
        end else if (d == DIR_DOWN) begin
`ifdef CURSOR_WRAP_EN
            step_row = (v == V_LAST) ? '0 : v + VW'(1);
`else
            step_row = (v == V_LAST) ? v : v + VW'(1);
`endif
        end
    endfunction

    // Decode the incoming event into a direction / home / release of the held key.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ev_dir       = DIR_NONE;
        ev_home_code = 1'b0;
        case (bus.key_code[7:0])
            8'h69:   ev_dir = DIR_LEFT;
            8'h7A:   ev_dir = DIR_RIGHT;
            8'h72:   ev_dir = DIR_UP;
            8'h73:   ev_dir = DIR_DOWN;
            8'h6C:   ev_home_code = 1'b1;
            default: ;
        endcase
        ev_dir_make  = bus.key_valid && !bus.key_code[8] && bus.key_make && (ev_dir != DIR_NONE);
        ev_home_make = bus.key_valid && !bus.key_code[8] && bus.key_make && ev_home_code;
        ev_release   = bus.key_valid && !bus.key_code[8] && !bus.key_make &&
                       (ev_dir != DIR_NONE) && (ev_dir == held_q);
    end

    // Next-state logic: key events take priority over the repeat timer.
    always_comb begin
        dir_e step_dir;
        logic do_step;

        state_d  = state_q;
        held_d   = held_q;
        cnt_d    = cnt_q;
        cur_h_d  = cur_h_q;
        cur_v_d  = cur_v_q;
        pulse_d  = 1'b0;
        step_dir = DIR_NONE;
        do_step  = 1'b0;

        if (ev_dir_make) begin
            step_dir = ev_dir;
            do_step  = 1'b1;
            held_d   = ev_dir;
            cnt_d    = '0;
            state_d  = ST_FIRST;
        end else if (ev_home_make) begin
            cur_h_d = '0;
            cur_v_d = '0;
            pulse_d = (cur_h_q != '0) || (cur_v_q != '0);
            held_d  = DIR_NONE;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (ev_release) begin
            held_d  = DIR_NONE;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_FIRST: begin
                    if (cnt_q == FD_LAST) begin
                        step_dir = held_q;
                        do_step  = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (cnt_q == RP_LAST) begin
                        step_dir = held_q;
                        do_step  = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end

        // A clamped move leaves the position alone and so raises no pulse.
        if (do_step) begin
            cur_h_d = step_col(cur_h_q, step_dir);
            cur_v_d = step_row(cur_v_q, step_dir);
            pulse_d = (cur_h_d != cur_h_q) || (cur_v_d != cur_v_q);
        end
    end

    // State, timer and registered outputs; rst wins over any key event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            held_q  <= DIR_NONE;
            cnt_q   <= '0;
            cur_h_q <= '0;
            cur_v_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            cur_h_q <= cur_h_d;
            cur_v_q <= cur_v_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.cur_h      = cur_h_q;
    assign bus.cur_v      = cur_v_q;
    assign bus.move_pulse = pulse_q;
    assign bus.held_dir   = held_q;

endmodule

// File: tb/tb_tile_cursor_ctrl.sv
// tb_tile_cursor_ctrl: directed plus random stimulus for tile_cursor_ctrl on
// a 4x3 grid (FIRST_DELAY=8, REPEAT_PERIOD=3). A scheduling model predicts
// position, pulse and held direction and is compared every cycle; directed
// literals pin the model. Honors CURSOR_WRAP_EN like the design.
module tb_tile_cursor_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int HW = 2;
    localparam int VW = 2;
    localparam int CW = 4;
    localparam int FD = 8;
    localparam int RP = 3;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    tile_cursor_if #(.HW(HW), .VW(VW)) bus ();

    tile_cursor_ctrl #(
        .H_TILES(H), .V_TILES(V), .HW(HW), .VW(VW), .CW(CW),
        .FIRST_DELAY(FD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position as plain integers; auto-repeat as an absolute edge number at
    // which the next move is due (-1 when nothing is held).
    int  m_h = 0, m_v = 0, m_held = 0, m_pulse = 0;
    int  edge_no = 0;
    int  next_move = -1;
    bit  started = 1'b0;

    function automatic int code_dir(input logic [7:0] c);
        case (c)
            8'h69:   return 1;
            8'h7A:   return 2;
            8'h72:   return 3;
            8'h73:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void model_move(input int d);
        int nh = m_h;
        int nv = m_v;
        if (d == 1) nh--;
        if (d == 2) nh++;
        if (d == 3) nv--;
        if (d == 4) nv++;
        if (WRAP) begin
            nh = (nh + H) % H;
            nv = (nv + V) % V;
        end else begin
            nh = (nh < 0) ? 0 : ((nh > H - 1) ? H - 1 : nh);
            nv = (nv < 0) ? 0 : ((nv > V - 1) ? V - 1 : nv);
        end
        m_pulse = (nh != m_h || nv != m_v) ? 1 : 0;
        m_h = nh;
        m_v = nv;
    endfunction

    always @(posedge clk) begin
        int  d;
        bit  ok;
        edge_no++;
        m_pulse = 0;
        d  = code_dir(bus.key_code[7:0]);
        ok = bus.key_valid && !bus.key_code[8];
        if (rst) begin
            m_h = 0; m_v = 0; m_held = 0; next_move = -1;
        end else if (ok && bus.key_make && d != 0) begin
            model_move(d);
            m_held    = d;
            next_move = edge_no + FD;
        end else if (ok && bus.key_make && bus.key_code[7:0] == 8'h6C) begin
            m_pulse   = (m_h != 0 || m_v != 0) ? 1 : 0;
            m_h = 0; m_v = 0; m_held = 0; next_move = -1;
        end else if (ok && !bus.key_make && d != 0 && d == m_held) begin
            m_held = 0; next_move = -1;
        end else if (m_held != 0 && edge_no == next_move) begin
            model_move(m_held);
            next_move = edge_no + RP;
        end
        started = 1'b1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("model_cur_h", 32'(bus.cur_h), m_h);
            check("model_cur_v", 32'(bus.cur_v), m_v);
            check("model_pulse", 32'(bus.move_pulse), m_pulse);
            check("model_held", 32'(bus.held_dir), m_held);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] code, input logic make);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        bus.key_make  = make;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_out(input string name, input int h, input int v, input int p, input int hd);
        check({name, "_h"}, 32'(bus.cur_h), h);
        check({name, "_v"}, 32'(bus.cur_v), v);
        check({name, "_pulse"}, 32'(bus.move_pulse), p);
        check({name, "_held"}, 32'(bus.held_dir), hd);
    endtask

    logic [8:0] codes [8];

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = '0;
        bus.key_make  = 1'b0;
        codes = '{9'h069, 9'h07A, 9'h072, 9'h073, 9'h06C, 9'h169, 9'h17A, 9'h01C};

        wait_cycles(2);
        expect_out("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Right make, then hold: moves at +8 and every +3, clamping at column 3.
        send(9'h07A, 1'b1);                       // edge N
        expect_out("right_make", 1, 0, 1, 2);
        wait_cycles(1);
        expect_out("right_pulse_drop", 1, 0, 0, 2);
        wait_cycles(6);                           // after N+7
        expect_out("before_first_rep", 1, 0, 0, 2);
        wait_cycles(1);                           // N+8
        expect_out("first_rep", 2, 0, 1, 2);
        wait_cycles(3);                           // N+11
        expect_out("second_rep", 3, 0, 1, 2);
        wait_cycles(3);                           // N+14
        expect_out("edge_rep", WRAP ? 0 : 3, 0, WRAP ? 1 : 0, 2);
        send(9'h07A, 1'b0);
        check("right_break_held", 32'(bus.held_dir), 0);
        send(9'h06C, 1'b1);
        expect_out("home_a", 0, 0, WRAP ? 0 : 1, 0);

        // Up at row 0, then down; stray break of up keeps the repeat alive.
        send(9'h072, 1'b1);
        expect_out("up_at_top", 0, WRAP ? 2 : 0, WRAP ? 1 : 0, 3);
        send(9'h073, 1'b1);                       // edge N
        expect_out("down_make", 0, WRAP ? 0 : 1, 1, 4);
        wait_cycles(1);
        send(9'h072, 1'b0);                       // N+2, not the held key
        check("stray_break_held", 32'(bus.held_dir), 4);
        wait_cycles(5);                           // N+7
        check("down_no_pulse", 32'(bus.move_pulse), 0);
        wait_cycles(1);                           // N+8
        expect_out("down_rep", 0, WRAP ? 1 : 2, 1, 4);
        send(9'h073, 1'b0);
        check("down_break_held", 32'(bus.held_dir), 0);
        wait_cycles(10);
        expect_out("after_break", 0, WRAP ? 1 : 2, 0, 0);

        // Walk to column 3, extended code ignored, then home.
        send(9'h07A, 1'b1);
        send(9'h07A, 1'b1);
        send(9'h07A, 1'b1);
        expect_out("walk_right", 3, WRAP ? 1 : 2, 1, 2);
        send(9'h169, 1'b1);
        expect_out("extended", 3, WRAP ? 1 : 2, 0, 2);
        send(9'h06C, 1'b1);
        expect_out("home_b", 0, 0, 1, 0);

        // Key event on the same edge as the first timer expiry.
        send(9'h07A, 1'b1);                       // edge N
        wait_cycles(7);                           // after N+7
        send(9'h073, 1'b1);                       // N+8 = expiry edge
        expect_out("collide", 1, 1, 1, 4);
        wait_cycles(7);                           // N+15
        expect_out("collide_wait", 1, 1, 0, 4);
        wait_cycles(1);                           // N+16
        expect_out("collide_rep", 1, 2, 1, 4);
        wait_cycles(3);                           // N+19, in REPEAT
        check("collide_edge_v", 32'(bus.cur_v), WRAP ? 0 : 2);

        // Reset while repeating.
        pulse_rst();
        expect_out("mid_rst", 0, 0, 0, 0);
        wait_cycles(20);
        expect_out("rst_no_resume", 0, 0, 0, 0);

        // Random traffic, all checked by the per-cycle model comparison.
        for (int i = 0; i < 400; i++) begin
            wait_cycles($urandom_range(0, (i % 5 == 0) ? 25 : 6));
            if ($urandom_range(0, 39) == 0) begin
                pulse_rst();
            end else begin
                send(codes[$urandom_range(0, 7)], ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
            end
        end
        wait_cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
